// File: rtl/bus_master_seq.sv
// Register-file bus initiator: cmd stream in, one rsp per bus access out.
// Optional BUS_MASTER_BURST_EN: cmd_len+1 beats at incrementing addresses.
module bus_master_seq #(
  parameter int RD_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic [7:0]  cmd_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_wr,
  output logic [15:0] rsp_addr,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic [33:0] ibus,
  input  logic [15:0] obus
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RDWAIT,
    RESP
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(RD_WAIT);

  state_t      state;
  logic        bwr;
  logic [15:0] baddr;
  logic [15:0] bwrdata;
  logic        wph;
  logic [3:0]  cnt;
  logic        lat_wr;

`ifdef BUS_MASTER_BURST_EN
  logic [7:0]  beats;
`else
  logic        unused_len;
  assign unused_len = ^cmd_len;
`endif

  assign cmd_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign ibus      = {clk, bwr, baddr, bwrdata};

  // Sequencer: launches bus cycles, times read sampling, holds responses.
  // A write drives bwr for one cycle, then idles one cycle so the
  // responder's capture edge has passed before the response is raised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bwr       <= 1'b0;
      baddr     <= '0;
      bwrdata   <= '0;
      wph       <= 1'b0;
      cnt       <= '0;
      lat_wr    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
`ifdef BUS_MASTER_BURST_EN
      beats     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            lat_wr  <= cmd_wr;
            baddr   <= cmd_addr;
            bwrdata <= cmd_data;
`ifdef BUS_MASTER_BURST_EN
            beats   <= cmd_len;
`endif
            if (cmd_wr) begin
              bwr   <= 1'b1;
              wph   <= 1'b0;
              state <= WRITE;
            end else begin
              bwr   <= 1'b0;
              cnt   <= WAIT_LD;
              state <= RDWAIT;
            end
          end
        end
        WRITE: begin
          if (!wph) begin
            bwr <= 1'b0;
            wph <= 1'b1;
          end else begin
            bwr       <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_wr    <= 1'b1;
            rsp_addr  <= baddr;
            rsp_data  <= bwrdata;
            state     <= RESP;
          end
        end
        RDWAIT: begin
          if (cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_wr    <= 1'b0;
            rsp_addr  <= baddr;
            rsp_data  <= obus;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef BUS_MASTER_BURST_EN
            if (beats != 8'd0) begin
              beats <= beats - 8'd1;
              baddr <= baddr + 16'd1;
              if (lat_wr) begin
                bwr   <= 1'b1;
                wph   <= 1'b0;
                state <= WRITE;
              end else begin
                cnt   <= WAIT_LD;
                state <= RDWAIT;
              end
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_seq.sv
// Directed bench for bus_master_seq with bregpl@0x0010 and
// brorpl@0x0020 (0xBEEF) responder models on ibus/obus.
module tb_bus_master_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_data;
  logic [7:0]  cmd_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_wr;
  logic [15:0] rsp_addr;
  logic [15:0] rsp_data;
  logic        busy;
  logic [33:0] ibus;
  logic [15:0] obus;

  bus_master_seq #(.RD_WAIT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_wr    (rsp_wr),
    .rsp_addr  (rsp_addr),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .ibus      (ibus),
    .obus      (obus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // bregpl at 0x0010 and brorpl at 0x0020
  logic [15:0] r10 = 16'h0;
  always @(posedge clk)
    if (ibus[32] && ibus[31:16] == 16'h0010)
      r10 <= ibus[15:0];

  assign obus =
    (ibus[31:16] == 16'h0010 ? r10 : 16'h0) |
    (ibus[31:16] == 16'h0020 ? 16'hBEEF : 16'h0);

  int bwr_n = 0;
  always @(negedge clk)
    if (ibus[32]) bwr_n <= bwr_n + 1;

  // response log, written only here
  logic [15:0] la [64];
  logic [15:0] ld [64];
  logic        lw [64];
  int          lc [64];
  int          wi = 0;
  always @(negedge clk)
    if (rsp_valid && rsp_ready && wi < 64) begin
      la[wi] <= rsp_addr;
      ld[wi] <= rsp_data;
      lw[wi] <= rsp_wr;
      lc[wi] <= cyc;
      wi     <= wi + 1;
    end

  int nchk = 0;
  int nfail = 0;
  int ri = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic wr,
                      input logic [15:0] a,
                      input logic [15:0] d,
                      input logic [7:0] len,
                      input bit keep,
                      output int acc);
    bit ok = 0;
    acc = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_len   = len;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        ok  = 1;
        break;
      end
      @(negedge clk);
    end
    if (!keep) cmd_valid = 1'b0;
    if (!ok) chk("cmd_timeout", 0, 1);
  endtask

  task automatic get_rsp(output logic w,
                         output logic [15:0] a,
                         output logic [15:0] d,
                         output int c);
    bit ok = 0;
    w = 0; a = 0; d = 0; c = 0;
    for (int i = 0; i < 60; i++) begin
      if (wi > ri) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("rsp_timeout", 0, 1);
    end else begin
      w = lw[ri];
      a = la[ri];
      d = ld[ri];
      c = lc[ri];
      ri++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] d0;
    int          c;
    int          acc;
    int          acc2;
    int          b0;
    int          dev;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_len   = '0;
    rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ibus", ibus[32:0], 0);
    chk("rst_rsp_data", rsp_data, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);

    // 1: single write
    b0 = bwr_n;
    send(1, 16'h0010, 16'h1234, 0, 0, acc);
    get_rsp(w, a, d, c);
    chk("t1_lat", c - acc, 2);
    chk("t1_data", d, 16'h1234);
    chk("t1_wr", w, 1);
    chk("t1_addr", a, 16'h0010);
    repeat (2) @(negedge clk);
    chk("t1_bwr_cycles", bwr_n - b0, 1);

    // 2: read back and constant responder
    send(0, 16'h0010, 16'h0, 0, 0, acc);
    get_rsp(w, a, d, c);
    chk("t2_lat", c - acc, 3);
    chk("t2_data", d, 16'h1234);
    chk("t2_wr", w, 0);
    send(0, 16'h0020, 16'h0, 0, 0, acc);
    get_rsp(w, a, d, c);
    chk("t2_beef", d, 16'hBEEF);
    @(negedge clk);
    chk("t2_idle_baddr", ibus[31:16], 16'h0020);
    chk("t2_idle_bwr", ibus[32], 0);

    // 3: response backpressure
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    send(0, 16'h0010, 16'h0, 0, 0, acc);
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    d0  = rsp_data;
    dev = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== d0 || cmd_ready ||
          ibus[32] || ibus[31:16] !== 16'h0010)
        dev++;
    end
    chk("t3_stall_dev", dev, 0);
    chk("t3_held_data", d0, 16'h1234);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    get_rsp(w, a, d, c);
    chk("t3_data", d, 16'h1234);

    // 4: reset pulse in RDWAIT
    send(0, 16'h0010, 16'h0, 0, 0, acc);
    @(negedge clk);
    chk("t4_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    chk("t4_bwr", ibus[32], 0);
    chk("t4_rsp_valid", rsp_valid, 0);
    chk("t4_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_no_rsp", wi - ri, 0);
    send(0, 16'h0020, 16'h0, 0, 0, acc);
    get_rsp(w, a, d, c);
    chk("t4_beef", d, 16'hBEEF);

    // 4b: reset while bwr is high loses the write
    send(1, 16'h0010, 16'h5555, 0, 0, acc);
    chk("t4b_bwr_pre", ibus[32], 1);
    reset = 1'b1;
    #1;
    chk("t4b_bwr", ibus[32], 0);
    @(negedge clk);
    reset = 1'b0;
    send(0, 16'h0010, 16'h0, 0, 0, acc);
    get_rsp(w, a, d, c);
    chk("t4b_lost", d, 16'h1234);

    // 5: back-to-back write then read
    send(1, 16'h0010, 16'hAAAA, 0, 1, acc);
    send(0, 16'h0010, 16'h0, 0, 0, acc2);
    get_rsp(w, a, d, c);
    chk("t5_wr_rsp", {w, d}, {1'b1, 16'hAAAA});
    get_rsp(w, a, d, c);
    chk("t5_rd_rsp", {w, d}, {1'b0, 16'hAAAA});

`ifdef BUS_MASTER_BURST_EN
    // 6: burst read wrapping at 0xFFFF
    send(0, 16'hFFFF, 16'h0, 2, 0, acc);
    get_rsp(w, a, d, c);
    chk("t6_addr0", a, 16'hFFFF);
    get_rsp(w, a, d, c);
    chk("t6_addr1", a, 16'h0000);
    get_rsp(w, a, d, c);
    chk("t6_addr2", a, 16'h0001);
    repeat (8) @(negedge clk);
    chk("t6_count", wi - ri, 0);
`else
    // 6: cmd_len ignored, single beat only
    send(0, 16'h0020, 16'h0, 3, 0, acc);
    get_rsp(w, a, d, c);
    chk("t6_single", d, 16'hBEEF);
    repeat (10) @(negedge clk);
    chk("t6_no_extra", wi - ri, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
